round_ctrl: RTL and testbench
=============================

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter DELAY_BASE, default 50_000_000, minimum lights-off delay in cycles (>=1).
REQ-002 SHALL have parameter RAND_BITS, default 8, number of LFSR bits added to the delay (0 = fixed delay).
REQ-003 SHALL have parameter RAND_SHIFT, default 18, left shift applied to the random addend.
REQ-004 SHALL have parameter LIGHTS_MAX, default 150_000_000, maximum cycles the lights stay on awaiting a push (>=1).
REQ-005 SHALL have ports in this order: clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 pbl  in  1  left button, already synchronized and debounced, active-high level.
REQ-008 pbr  in  1  right button, same conditioning as pbl.
REQ-009 game_over  in  1  high when the scorer shows WL or WR.
REQ-010 leds_on  out  1  lights-on indicator; also qualifies the push reported with winrnd.
REQ-011 winrnd  out  1  one-cycle pulse: one valid push decided.
REQ-012 right  out  1  push winner: 1 = right player, 0 = left player; valid while winrnd=1.
REQ-013 state_dbg  out  3  current state encoding.

Function
REQ-014 SHALL implement states RELEASE, DELAY, LIGHTS, SCORE, DONE.
REQ-015 RELEASE: if game_over=1, go to DONE; else if pbl=0 and pbr=0, go to DELAY and load the counter with D = DELAY_BASE + (lfsr[RAND_BITS-1:0] << RAND_SHIFT); else stay in RELEASE.
REQ-016 DELAY SHALL last exactly D cycles when no button is pressed, then go to LIGHTS with the counter loaded to LIGHTS_MAX.
REQ-017 A single push in DELAY (exactly one of pbl/pbr high) SHALL go to SCORE next cycle with leds_on=0 there; right = pbr.
REQ-018 In LIGHTS, leds_on SHALL be 1 for every cycle the block is in that state.
REQ-019 A single push in LIGHTS SHALL go to SCORE next cycle with leds_on=1 there; right = pbr.
REQ-020 If pbl and pbr are both high in the same cycle in DELAY or LIGHTS, the block SHALL go to RELEASE with no winrnd (tie, no point).
REQ-021 LIGHTS with no push for LIGHTS_MAX cycles SHALL go to RELEASE with no winrnd; a push sampled on the expiry cycle SHALL take priority over the timeout.
REQ-022 SCORE SHALL last exactly one cycle with winrnd=1, with right and leds_on held at the values captured at the push; the next state is RELEASE.
REQ-023 winrnd SHALL be 1 only in SCORE; leds_on SHALL be 0 in RELEASE, DELAY, and DONE.
REQ-024 DONE is absorbing until rst; in DONE, leds_on=0, winrnd=0, right=0, and buttons are ignored.
REQ-025 Push-to-winrnd latency SHALL be exactly 1 cycle; all outputs SHALL be registered or decoded from the state only.
REQ-026 A free-running 16-bit LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle, including in DONE; it SHALL never reach all-zeros.
REQ-027 The delay counter SHALL be wide enough for max(DELAY_BASE + ((2^RAND_BITS-1) << RAND_SHIFT), LIGHTS_MAX) with no wrap-around.

Reset
REQ-028 On rst=1, the block SHALL asynchronously go to RELEASE, with leds_on=0, winrnd=0, right=0, counter=0, and LFSR=16'hACE1.
REQ-029 A reset asserted during any state, including SCORE, SHALL abort the round with no winrnd pulse after the reset edge.
REQ-030 After reset deassertion, buttons held low SHALL reach DELAY on the first clock edge.

Structure
REQ-031 The state encodings (RELEASE=0, DELAY=1, LIGHTS=2, SCORE=3, DONE=4), the LFSR seed, and the tap mask SHALL live in the shared package tow_pkg.
REQ-032 The LFSR SHALL be a sub-module lfsr16 (clk, rst, q[15:0]); everything else SHALL stay in round_ctrl.

Verification
All scenarios use DELAY_BASE=4, RAND_BITS=0, LIGHTS_MAX=6 unless stated otherwise.
REQ-033 Proper push: buttons low from reset; LIGHTS entered at cycle 5; pbr=1 at cycle 7 -> cycle 8 has winrnd=1, right=1, leds_on=1, then RELEASE.
REQ-034 Jump the light: pbl=1 at the 2nd DELAY cycle -> next cycle has winrnd=1, right=0, leds_on=0, and LIGHTS is never entered.
REQ-035 Tie: pbl=pbr=1 in the same LIGHTS cycle -> no winrnd; RELEASE; DELAY after both buttons are released.
REQ-036 Timeout: no push -> leds_on=1 for exactly 6 cycles, then 0, with no winrnd; push on the 6th LIGHTS cycle -> winrnd with leds_on=1.
REQ-037 Game over: game_over=1 in RELEASE after a SCORE -> DONE (state_dbg=4); further pushes produce no winrnd until rst.
REQ-038 Randomness: RAND_BITS=4, RAND_SHIFT=0 -> each measured DELAY length lies in 4..19, and at least two distinct lengths occur across 8 rounds.

Source files
------------

// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared state encodings and LFSR constants for the tug-of-war game
package tow_pkg;

    typedef enum logic [2:0] {
        ST_RELEASE = 3'd0,
        ST_DELAY   = 3'd1,
        ST_LIGHTS  = 3'd2,
        ST_SCORE   = 3'd3,
        ST_DONE    = 3'd4
    } round_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 for a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running maximal-length 16-bit LFSR, never reaches all-zeros
module lfsr16
    import tow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - one reaction round: random delay, lights window, push arbitration
module round_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned DELAY_BASE = 50_000_000,
    parameter int unsigned RAND_BITS  = 8,
    parameter int unsigned RAND_SHIFT = 18,
    parameter int unsigned LIGHTS_MAX = 150_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       game_over,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic [2:0] state_dbg
);

    localparam longint unsigned RAND_ADD_MAX =
        (RAND_BITS == 0) ? 64'd0 : (((64'd1 << RAND_BITS) - 64'd1) << RAND_SHIFT);
    localparam longint unsigned DELAY_MAX = 64'(DELAY_BASE) + RAND_ADD_MAX;
    localparam longint unsigned CNT_MAX   =
        (DELAY_MAX > 64'(LIGHTS_MAX)) ? DELAY_MAX : 64'(LIGHTS_MAX);
    localparam int CNT_W = $clog2(CNT_MAX + 64'd1);
    localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

    round_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             right_q, right_d;
    logic             led_q, led_d;

    logic [15:0]      lfsr;
    logic [63:0]      rand_wide;
    logic [CNT_W-1:0] delay_load;
    logic             single_push;
    logic             both_push;
    logic             cnt_last;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Masking the whole register keeps the addend well-defined when RAND_BITS is 0
    assign rand_wide   = {48'd0, lfsr & RAND_MASK} << RAND_SHIFT;
    assign delay_load  = CNT_W'(64'(DELAY_BASE) + rand_wide);
    assign single_push = pbl ^ pbr;
    assign both_push   = pbl & pbr;
    assign cnt_last    = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            right_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        led_d   = led_q;
        unique case (state_q)
            ST_RELEASE: begin
                if (game_over) begin
                    state_d = ST_DONE;
                end else if (!pbl && !pbr) begin
                    state_d = ST_DELAY;
                    cnt_d   = delay_load;
                end
            end
            ST_DELAY: begin
                if (both_push) begin
                    state_d = ST_RELEASE;
                end else if (single_push) begin
                    state_d = ST_SCORE;
                    right_d = pbr;
                    led_d   = 1'b0;
                end else if (cnt_last) begin
                    state_d = ST_LIGHTS;
                    cnt_d   = CNT_W'(LIGHTS_MAX);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LIGHTS: begin
                // A push on the final lights cycle wins over the timeout
                if (both_push) begin
                    state_d = ST_RELEASE;
                end else if (single_push) begin
                    state_d = ST_SCORE;
                    right_d = pbr;
                    led_d   = 1'b1;
                end else if (cnt_last) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SCORE: begin
                state_d = ST_RELEASE;
                right_d = 1'b0;
                led_d   = 1'b0;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RELEASE;
            end
        endcase
    end

    assign winrnd    = (state_q == ST_SCORE);
    assign leds_on   = (state_q == ST_LIGHTS) || ((state_q == ST_SCORE) && led_q);
    assign right     = right_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - directed self-checking bench for round_ctrl
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pbl, pbr, game_over;
    logic       leds_on, winrnd, right;
    logic [2:0] state_dbg;
    logic       leds_on2, winrnd2, right2;
    logic [2:0] state_dbg2;
    logic       zero_in = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    round_ctrl #(
        .DELAY_BASE(4), .RAND_BITS(0), .RAND_SHIFT(0), .LIGHTS_MAX(6)
    ) u_dut (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .game_over(game_over),
        .leds_on(leds_on), .winrnd(winrnd), .right(right), .state_dbg(state_dbg)
    );

    round_ctrl #(
        .DELAY_BASE(4), .RAND_BITS(4), .RAND_SHIFT(0), .LIGHTS_MAX(6)
    ) u_dut_rand (
        .clk(clk), .rst(rst), .pbl(zero_in), .pbr(zero_in), .game_over(zero_in),
        .leds_on(leds_on2), .winrnd(winrnd2), .right(right2), .state_dbg(state_dbg2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[$];
        int run;
        bit seen_start;
        logic [2:0] prev;
        bit distinct;

        rst = 1'b1; pbl = 1'b0; pbr = 1'b0; game_over = 1'b0;
        steps(2);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_leds", 32'(leds_on), 32'd0);
        check("rst_winrnd", 32'(winrnd), 32'd0);
        check("rst_right", 32'(right), 32'd0);
        check("rst_lfsr", 32'(u_dut.u_lfsr.q), 32'hACE1);

        // Proper push: cycle 0 is RELEASE, DELAY 1..4, LIGHTS from 5
        rst = 1'b0;
        check("c0_release", 32'(state_dbg), 32'd0);
        step();
        check("c1_delay", 32'(state_dbg), 32'd1);
        check("lfsr_step", 32'(u_dut.u_lfsr.q), 32'hE270);
        steps(3);
        check("c4_delay", 32'(state_dbg), 32'd1);
        check("c4_leds", 32'(leds_on), 32'd0);
        step();
        check("c5_lights", 32'(state_dbg), 32'd2);
        check("c5_leds", 32'(leds_on), 32'd1);
        steps(2);
        check("c7_lights", 32'(state_dbg), 32'd2);
        pbr = 1'b1;
        step();
        check("push_state", 32'(state_dbg), 32'd3);
        check("push_winrnd", 32'(winrnd), 32'd1);
        check("push_right", 32'(right), 32'd1);
        check("push_leds", 32'(leds_on), 32'd1);
        pbr = 1'b0;
        step();
        check("push_release", 32'(state_dbg), 32'd0);
        check("push_win_clear", 32'(winrnd), 32'd0);
        step();
        check("push_redelay", 32'(state_dbg), 32'd1);

        // Jump the light on the second DELAY cycle
        step();
        pbl = 1'b1;
        step();
        check("jump_state", 32'(state_dbg), 32'd3);
        check("jump_winrnd", 32'(winrnd), 32'd1);
        check("jump_right", 32'(right), 32'd0);
        check("jump_leds", 32'(leds_on), 32'd0);
        pbl = 1'b0;
        step();
        check("jump_release", 32'(state_dbg), 32'd0);
        step();
        check("jump_redelay", 32'(state_dbg), 32'd1);

        // Tie inside LIGHTS
        steps(4);
        check("tie_lights", 32'(state_dbg), 32'd2);
        pbl = 1'b1; pbr = 1'b1;
        step();
        check("tie_state", 32'(state_dbg), 32'd0);
        check("tie_winrnd", 32'(winrnd), 32'd0);
        step();
        check("tie_hold_both", 32'(state_dbg), 32'd0);
        pbl = 1'b0;
        step();
        check("tie_hold_one", 32'(state_dbg), 32'd0);
        pbr = 1'b0;
        step();
        check("tie_redelay", 32'(state_dbg), 32'd1);

        // Timeout: six lit cycles, no point
        steps(4);
        for (int i = 0; i < 6; i++) begin
            check("to_leds_on", 32'(leds_on), 32'd1);
            check("to_no_win", 32'(winrnd), 32'd0);
            step();
        end
        check("to_leds_off", 32'(leds_on), 32'd0);
        check("to_release", 32'(state_dbg), 32'd0);
        check("to_no_win_end", 32'(winrnd), 32'd0);
        step();
        check("to_redelay", 32'(state_dbg), 32'd1);

        // Push on the final lights cycle beats the timeout
        steps(4);
        steps(5);
        check("last_lights", 32'(state_dbg), 32'd2);
        pbl = 1'b1;
        step();
        check("last_winrnd", 32'(winrnd), 32'd1);
        check("last_leds", 32'(leds_on), 32'd1);
        check("last_right", 32'(right), 32'd0);
        pbl = 1'b0;

        // Game over after a SCORE
        game_over = 1'b1;
        step();
        check("go_release", 32'(state_dbg), 32'd0);
        step();
        check("go_done", 32'(state_dbg), 32'd4);
        pbl = 1'b1;
        step();
        check("done_pbl_win", 32'(winrnd), 32'd0);
        check("done_pbl_state", 32'(state_dbg), 32'd4);
        pbl = 1'b0; pbr = 1'b1;
        step();
        check("done_pbr_win", 32'(winrnd), 32'd0);
        check("done_right", 32'(right), 32'd0);
        check("done_leds", 32'(leds_on), 32'd0);
        pbr = 1'b0;
        steps(3);
        check("done_absorb", 32'(state_dbg), 32'd4);

        // Asynchronous reset, including one landing in SCORE
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state_dbg), 32'd0);
        step();
        rst = 1'b0; game_over = 1'b0;
        step();
        check("arst_delay", 32'(state_dbg), 32'd1);
        pbr = 1'b1;
        step();
        check("score_pre_rst", 32'(winrnd), 32'd1);
        pbr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("score_rst_win", 32'(winrnd), 32'd0);
        check("score_rst_state", 32'(state_dbg), 32'd0);
        step();
        check("score_rst_hold", 32'(winrnd), 32'd0);
        rst = 1'b0;

        // Randomised delay lengths on the second instance
        run = 0;
        seen_start = 1'b0;
        prev = state_dbg2;
        for (int c = 0; c < 1500 && lens.size() < 8; c++) begin
            step();
            if (state_dbg2 == 3'd1) begin
                if (prev != 3'd1) begin
                    run = 1;
                    seen_start = 1'b1;
                end else begin
                    run++;
                end
            end else if (prev == 3'd1 && seen_start) begin
                lens.push_back(run);
            end
            prev = state_dbg2;
        end
        check("rand_rounds", 32'(lens.size()), 32'd8);
        distinct = 1'b0;
        foreach (lens[i]) begin
            check("rand_len_range", 32'((lens[i] >= 4) && (lens[i] <= 19)), 32'd1);
            if (lens[i] != lens[0]) distinct = 1'b1;
        end
        check("rand_distinct", 32'(distinct), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
